// File: rtl/apu_arith_pkg.sv
// Shared constants and types for the APU arithmetic unit (multiplier/divider).
package apu_arith_pkg;

    localparam int unsigned DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/divider_step.sv
// One radix-2 restoring division step: shift {r,q} left, trial-subtract d.
module divider_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] trial;

    // r < d holds on entry, so r_shift < 2d and the sign bit of trial is exact.
    always_comb begin
        r_shift = {r, q[WIDTH-1]};
        trial   = r_shift - {1'b0, d};
        r_next  = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        q_next  = {q[WIDTH-2:0], ~trial[WIDTH]};
    end

endmodule

// File: rtl/iterative_divider.sv
// Unsigned sequential divider: one restoring step per clock behind start/done.
module iterative_divider
    import apu_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] r_step, q_step;

    divider_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .r      (r_q),
        .q      (q_q),
        .d      (d_q),
        .r_next (r_step),
        .q_next (q_step)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            RUN: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                    quo_d   = q_step;
                    rem_d   = r_step;
                    dbz_d   = 1'b0;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request.
                state_d = IDLE;
                if (start) begin
                    d_d   = divisor;
                    q_d   = dividend;
                    r_d   = '0;
                    cnt_d = '0;
                    if (divisor != '0) begin
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                        quo_d   = WIDTH'(DIV_ZERO_QUOTIENT);
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
